// File: rtl/main_control_fsm_if.sv
// Instruction handshake and data-memory request bus of the main control unit.
// The master side sources instructions and answers memory requests; the FSM is the slave.
interface main_control_fsm_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ack;
    logic        mem_read;
    logic        mem_write;

    modport master (
        output instr,
        output instr_valid,
        output mem_ack,
        input  instr_ready,
        input  mem_read,
        input  mem_write
    );

    modport slave (
        input  instr,
        input  instr_valid,
        input  mem_ack,
        output instr_ready,
        output mem_read,
        output mem_write
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 16-bit processor: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives ALU class and datapath enables, counts retired instructions.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | waiting for an instruction; instr_ready high
// S_DECODE | dispatch on latched opcode; JMP/HALT retire here
// S_EXEC   | ALU cycle; BEQ retires here
// S_MEM    | data memory access held until mem_ack or timeout
// S_WB     | single register-file write; retire
// S_HALT   | halted; only rst leaves
module main_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    main_control_fsm_if.slave bus,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic             branch,
    output logic             jump,
    output logic             pc_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic             mem_err,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_SLTI  = 4'b0111;
    localparam logic [3:0] OP_JMP   = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Last MEM cycle index: the counter would reach MEM_TIMEOUT at the end of it.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [7:0]  wait_cnt;
    logic        retire;
    logic        timeout;
    logic        fetch_fire;
    logic        unused_ir_bits;

    assign opcode         = ir[15:12];
    assign unused_ir_bits = ^ir[11:0];
    assign fetch_fire     = (state == S_FETCH) && bus.instr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= '0;
            wait_cnt <= '0;
            retired  <= '0;
            mem_err  <= 1'b0;
        end else begin
            mem_err <= timeout;
            if (fetch_fire) begin
                ir <= bus.instr;
            end
            if (state != S_MEM) begin
                wait_cnt <= '0;
            end else if (!bus.mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (retire) begin
                retired <= retired + RET_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_FETCH: begin
                if (bus.instr_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else if (opcode[3]) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_nxt = S_MEM;
                end else if (opcode == OP_BEQ) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                // An ack on the final wait cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    if (opcode == OP_LW) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        alu_op          = 3'b000;
        alu_src         = 1'b0;
        branch          = 1'b0;
        jump            = 1'b0;
        pc_write        = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        illegal_op      = 1'b0;
        halted          = 1'b0;
        case (state)
            S_FETCH: begin
                bus.instr_ready = 1'b1;
                pc_write        = bus.instr_valid;
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                end else if (opcode[3] && (opcode != OP_HALT)) begin
                    illegal_op = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin alu_op = 3'b010; alu_src = 1'b0; end
                    OP_ADDI:  begin alu_op = 3'b000; alu_src = 1'b1; end
                    OP_ANDI:  begin alu_op = 3'b011; alu_src = 1'b1; end
                    OP_ORI:   begin alu_op = 3'b100; alu_src = 1'b1; end
                    OP_LW:    begin alu_op = 3'b000; alu_src = 1'b1; end
                    OP_SW:    begin alu_op = 3'b000; alu_src = 1'b1; end
                    OP_BEQ:   begin alu_op = 3'b001; alu_src = 1'b0; branch = 1'b1; end
                    OP_SLTI:  begin alu_op = 3'b101; alu_src = 1'b1; end
                    default:  begin alu_op = 3'b000; alu_src = 1'b0; end
                endcase
            end
            S_MEM: begin
                bus.mem_read  = (opcode == OP_LW);
                bus.mem_write = (opcode == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LW);
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                bus.instr_ready = 1'b0;
            end
        endcase
    end

endmodule
